// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the pipelined RV32I core. It drives the
// hold enables of the PC, IF/DE, DE/EX and EX/MEM registers and the NOP-insert
// clears of IF/DE and DE/EX. It resolves load-use hazards, taken-branch
// flushes and multi-cycle data-memory waits, runs a short drain after reset
// and keeps saturating hazard statistics.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   rs1_de, rs2_de      source registers of the DE instruction
//   rs1_used_de/rs2_... DE instruction actually reads that source
//   rd_ex, RuWr_ex      destination / register-write enable of EX instruction
//   RUDataWrSrc_ex      EX writeback source, 2'b01 means load
//   NextPCSrc           taken branch/jump resolved in EX
//   dm_req_mem          MEM instruction accesses data memory
//   dm_ready            data memory completes the access this cycle
//   stall_pc/fd/de/em   hold PC, IF/DE, DE/EX, EX/MEM
//   clr_fd, clr_de      load NOP into IF/DE, DE/EX
//   mem_timeout         sticky flag: a memory wait ran into MAX_WAIT
//   stall_cnt           saturating count of stalled cycles
//   flush_cnt           saturating count of taken-branch flushes
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_WAIT     = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             rs1_used_de,
    input  logic             rs2_used_de,
    input  logic [4:0]       rd_ex,
    input  logic             RuWr_ex,
    input  logic [1:0]       RUDataWrSrc_ex,
    input  logic             NextPCSrc,
    input  logic             dm_req_mem,
    input  logic             dm_ready,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_de,
    output logic             stall_em,
    output logic             clr_fd,
    output logic             clr_de,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_DRAIN,
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    localparam logic [3:0] LP_DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] LP_MAX_WAIT   = 8'(MAX_WAIT);

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_drainCnt;
    logic [7:0]       r_waitCnt;
    logic             r_memTimeout;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_loadUse;
    logic w_memMiss;
    logic w_waitExpired;
    logic w_countStall;
    logic w_countFlush;

    // x0 never carries a dependency, and an unused source field is ignored.
    assign w_loadUse = RuWr_ex && (RUDataWrSrc_ex == 2'b01) && (rd_ex != 5'd0) &&
                       ((rs1_used_de && (rs1_de == rd_ex)) ||
                        (rs2_used_de && (rs2_de == rd_ex)));

    assign w_memMiss     = dm_req_mem && !dm_ready;
    assign w_waitExpired = (r_waitCnt == LP_MAX_WAIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DRAIN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_DRAIN: begin
                if (r_drainCnt == LP_DRAIN_LAST) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_memMiss) begin
                    w_nextState = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dm_ready || w_waitExpired) begin
                    w_nextState = ST_RUN;
                end
            end
            default: w_nextState = ST_DRAIN;
        endcase
    end

    // Output logic. Priority in RUN is memory wait, then branch, then
    // load-use; a branch flushes the DE instruction so its load-use is moot.
    always_comb begin
        stall_pc     = 1'b0;
        stall_fd     = 1'b0;
        stall_de     = 1'b0;
        stall_em     = 1'b0;
        clr_fd       = 1'b0;
        clr_de       = 1'b0;
        w_countStall = 1'b0;
        w_countFlush = 1'b0;
        if (!rst_n) begin
            clr_fd = 1'b1;
            clr_de = 1'b1;
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    clr_fd   = 1'b1;
                    clr_de   = 1'b1;
                    stall_pc = 1'b1;
                end
                ST_RUN: begin
                    if (w_memMiss) begin
                        stall_pc     = 1'b1;
                        stall_fd     = 1'b1;
                        stall_de     = 1'b1;
                        stall_em     = 1'b1;
                        w_countStall = 1'b1;
                    end else if (NextPCSrc) begin
                        clr_fd       = 1'b1;
                        clr_de       = 1'b1;
                        w_countFlush = 1'b1;
                    end else if (w_loadUse) begin
                        stall_pc     = 1'b1;
                        stall_fd     = 1'b1;
                        clr_de       = 1'b1;
                        w_countStall = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // The release cycle (ready or expired) drops every stall.
                    if (!dm_ready && !w_waitExpired) begin
                        stall_pc     = 1'b1;
                        stall_fd     = 1'b1;
                        stall_de     = 1'b1;
                        stall_em     = 1'b1;
                        w_countStall = 1'b1;
                    end
                end
                default: begin
                    clr_fd = 1'b1;
                    clr_de = 1'b1;
                end
            endcase
        end
    end

    // Drain and wait counters; the wait counter holds the number of frozen
    // cycles spent on the current access, starting at 1 on the entry cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drainCnt   <= 4'd0;
            r_waitCnt    <= 8'd0;
            r_memTimeout <= 1'b0;
        end else begin
            if ((r_state == ST_DRAIN) && (r_drainCnt != LP_DRAIN_LAST)) begin
                r_drainCnt <= r_drainCnt + 4'd1;
            end
            if ((r_state == ST_RUN) && w_memMiss) begin
                r_waitCnt <= 8'd1;
            end else if ((r_state == ST_MEM_WAIT) && !dm_ready && !w_waitExpired) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
            if ((r_state == ST_MEM_WAIT) && !dm_ready && w_waitExpired) begin
                r_memTimeout <= 1'b1;
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_countStall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (w_countFlush && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    assign mem_timeout = r_memTimeout;
    assign stall_cnt   = r_stallCnt;
    assign flush_cnt   = r_flushCnt;

endmodule
